hack_alu_seq: RTL

Parametrised, handshaked successor to the combinational Hack ALU. It implements the six-bit Hack control encoding (zx, nx, zy, ny, f, no) at configurable width, with a registered result and a carry flag. It also adds multi-cycle extended operations: logical/arithmetic shifts and an unsigned shift-add multiply. It sits between the CPU decode stage and the D/A/M writeback path, and stalls the core via a valid/ready handshake.

---
 rtl/hack_alu_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hack_alu_seq.sv
// Sequential Hack ALU with shift/multiply extensions; latency 1 (std), N+1 (shift by N), WIDTH+1 (mul).
// Accepts only in IDLE; the result is held in DONE until out_ready, which stalls the producer.
module hack_alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit EXT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic             ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy
);

    localparam int SAW = $clog2(WIDTH);
    localparam int CW  = SAW + 1;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 zr_q, zr_d;
    logic                 ng_q, ng_d;
    logic                 cy_q, cy_d;

    logic                 ext_eff;
    logic [SAW-1:0]       shamt;

    logic [WIDTH-1:0]     xa, xb, ya, yb, f_res, std_res;
    logic [WIDTH:0]       sum;
    logic                 std_cy;

    logic [WIDTH-1:0]     sh_next;
    logic                 sh_bit;
    logic [WIDTH:0]       mul_hi;
    logic [WIDTH-1:0]     mul_add;
    logic [2*WIDTH-1:0]   prod_next;

    logic                 load;
    logic [WIDTH-1:0]     load_val;
    logic                 load_cy;

    assign ext_eff = EXT_EN & ext;
    assign shamt   = y[SAW-1:0];

    // Hack function on the live inputs; only used on the accept edge.
    always_comb begin
        xa  = ctrl[5] ? '0 : x;
        xb  = ctrl[4] ? ~xa : xa;
        ya  = ctrl[3] ? '0 : y;
        yb  = ctrl[2] ? ~ya : ya;
        sum = {1'b0, xb} + {1'b0, yb};
        if (ctrl[1]) begin
            f_res  = sum[WIDTH-1:0];
            std_cy = sum[WIDTH];
        end else begin
            f_res  = xb & yb;
            std_cy = 1'b0;
        end
        std_res = ctrl[0] ? ~f_res : f_res;
    end

    // One CALC step: single-bit shift, or one shift-add multiply iteration.
    always_comb begin
        sh_next = sh_q;
        sh_bit  = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_next = {sh_q[WIDTH-2:0], 1'b0};
                sh_bit  = sh_q[WIDTH-1];
            end
            OP_SHR: begin
                sh_next = {1'b0, sh_q[WIDTH-1:1]};
                sh_bit  = sh_q[0];
            end
            default: begin
                sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                sh_bit  = sh_q[0];
            end
        endcase
        mul_add   = prod_q[0] ? sh_q : '0;
        mul_hi    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        prod_next = {mul_hi, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sh_d     = sh_q;
        prod_d   = prod_q;
        load     = 1'b0;
        load_val = '0;
        load_cy  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!ext_eff) begin
                        load     = 1'b1;
                        load_val = std_res;
                        load_cy  = std_cy;
                        state_d  = DONE;
                    end else begin
                        op_d = ctrl[1:0];
                        sh_d = x;
                        if (ctrl[1:0] == OP_MUL) begin
                            prod_d  = {{WIDTH{1'b0}}, y};
                            cnt_d   = CW'(WIDTH);
                            state_d = CALC;
                        end else if (shamt == '0) begin
                            load     = 1'b1;
                            load_val = x;
                            state_d  = DONE;
                        end else begin
                            cnt_d   = {1'b0, shamt};
                            state_d = CALC;
                        end
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    prod_d = prod_next;
                    if (cnt_q == CW'(1)) begin
                        load     = 1'b1;
                        load_val = prod_next[WIDTH-1:0];
                        load_cy  = |prod_next[2*WIDTH-1:WIDTH];
                        state_d  = DONE;
                    end
                end else begin
                    sh_d = sh_next;
                    if (cnt_q == CW'(1)) begin
                        load     = 1'b1;
                        load_val = sh_next;
                        load_cy  = sh_bit;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flags are registered alongside the result so they never disagree with it.
    always_comb begin
        out_d = out_q;
        zr_d  = zr_q;
        ng_d  = ng_q;
        cy_d  = cy_q;
        if (load) begin
            out_d = load_val;
            zr_d  = (load_val == '0);
            ng_d  = load_val[WIDTH-1];
            cy_d  = load_cy;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_SHL;
            sh_q    <= '0;
            prod_q  <= '0;
            out_q   <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            prod_q  <= prod_d;
            out_q   <= out_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            cy_q    <= cy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;

endmodule
